// File: rtl/fetch_if_id_stage.sv
// PC register, next-PC select and IF/ID pipeline register for the 5-stage core.
// Optional perf counters (StallCycles, SquashCount) are built when FETCH_PERF_CNT_EN is defined.
module fetch_if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_STALL = 3,
  parameter int          CNT_W     = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] Instr_in,
  output logic [31:0] PC_out,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        ID_EX_Bubble,
  output logic        StallTimeout
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] SquashCount
`endif
);

  // Stall-run counter only needs to reach MAX_STALL+1.
  localparam int SCNT_W = $clog2(MAX_STALL + 2);
  localparam logic [SCNT_W-1:0] STALL_LIMIT = SCNT_W'(MAX_STALL);
  localparam logic [SCNT_W-1:0] STALL_SAT   = SCNT_W'(MAX_STALL + 1);

  function automatic logic [31:0] alignTarget(input logic [31:0] t);
    return {t[31:2], 2'b00};
  endfunction

  function automatic logic [SCNT_W-1:0] satIncRun(input logic [SCNT_W-1:0] c);
    return (c >= STALL_SAT) ? STALL_SAT : c + 1'b1;
  endfunction

  logic [31:0]       pc_p0;
  logic [31:0]       instr_p1;
  logic [31:0]       pcPlus4_p1;
  logic              vld_p1;
  logic [SCNT_W-1:0] stallRun;
  logic              timeoutFlag;

  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] pcPlus4;

  always_comb begin
    redirect       = vld_p1 & (BranchTaken | Jump);
    redirectTarget = Jump ? alignTarget(JumpTarget) : alignTarget(BranchTarget);
    pcPlus4        = pc_p0 + 32'd4;
  end

  // IF stage: PC register; IF/ID boundary: instruction, PC+4 and valid.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_p0      <= RESET_PC;
      instr_p1   <= 32'h0;
      pcPlus4_p1 <= 32'h0;
      vld_p1     <= 1'b0;
    end else if (Stall) begin
      pc_p0      <= pc_p0;
      instr_p1   <= instr_p1;
      pcPlus4_p1 <= pcPlus4_p1;
      vld_p1     <= vld_p1;
    end else if (redirect) begin
      pc_p0      <= redirectTarget;
      instr_p1   <= 32'h0;
      pcPlus4_p1 <= 32'h0;
      vld_p1     <= 1'b0;
    end else begin
      pc_p0      <= pcPlus4;
      instr_p1   <= Instr_in;
      pcPlus4_p1 <= pcPlus4;
      vld_p1     <= 1'b1;
    end
  end

  // Timeout fires on the stall that would exceed the longest legal hazard run.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stallRun    <= '0;
      timeoutFlag <= 1'b0;
    end else if (Stall) begin
      stallRun <= satIncRun(stallRun);
      if (stallRun == STALL_LIMIT) begin
        timeoutFlag <= 1'b1;
      end
    end else begin
      stallRun <= '0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] satIncCnt(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] squashCount;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stallCycles <= '0;
      squashCount <= '0;
    end else if (Stall) begin
      stallCycles <= satIncCnt(stallCycles);
    end else if (redirect) begin
      squashCount <= satIncCnt(squashCount);
    end
  end

  assign StallCycles = stallCycles;
  assign SquashCount = squashCount;
`endif

  assign PC_out        = pc_p0;
  assign IF_ID_Instr   = instr_p1;
  assign IF_ID_PCPlus4 = pcPlus4_p1;
  assign IF_ID_Valid   = vld_p1;
  assign ID_EX_Bubble  = Stall | ~vld_p1;
  assign StallTimeout  = timeoutFlag;

endmodule
